// File: rtl/sdrd_ctrl_if.sv
// ICB bus bundle between the CPU-side master and the sdrd_ctrl register slave.
//   icb_cmd_*  : command channel (valid/ready, byte address, read flag, write data, byte mask)
//   icb_rsp_*  : response channel (valid/ready, error flag, read data)
interface sdrd_ctrl_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

// File: rtl/sdrd_ctrl.sv
// Multi-sector read sequencer between the ICB bus and a 1-bit SD sector-reader core.
// Issues one core request per sector, packs each 512 B sector into one of two
// ping-pong word banks, and exposes CTRL/SECTOR/COUNT/STATUS registers plus a level irq.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus             : ICB slave (register and bank read/write access)
//   core_rstart     : one-cycle sector request, core_rsector holds the sector number
//   core_rbusy/rdone: core busy level and sector-complete pulse
//   core_outen/outaddr/outbyte : byte stream from the core (index 0..511)
//   core_card_stat/card_type   : card init state and type, reflected in STATUS
//   irq             : level interrupt (irq_en & any sticky/bank-full flag)
module sdrd_ctrl #(
  parameter logic [23:0] TIMEOUT         = 24'd10_000_000,
  parameter logic [3:0]  CARD_READY_STAT = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  sdrd_ctrl_if.slave  bus,
  output logic        core_rstart,
  output logic [31:0] core_rsector,
  input  logic        core_rbusy,
  input  logic        core_rdone,
  input  logic        core_outen,
  input  logic [8:0]  core_outaddr,
  input  logic [7:0]  core_outbyte,
  input  logic [3:0]  core_card_stat,
  input  logic [1:0]  core_card_type,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_BUF, S_ISSUE, S_XFER, S_ABORT} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_sector, r_cur_sector;
  logic [15:0] r_count, r_remaining;
  logic [23:0] r_timer;
  logic        r_irq_en, r_fill_bank, r_done, r_err;
  logic [1:0]  r_full;
  logic        r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [3:0][7:0] r_buf [0:255];  // index = {bank, word}

  logic        w_accept, w_wr, w_ctrl_wr, w_start, w_abort, w_card_ready, w_busy;
  logic        w_timeout, w_fill_done, w_enter_abort, w_rd_err;
  logic [1:0]  w_release;
  logic [9:0]  w_widx;
  logic [31:0] w_rdata, w_status;
  logic        w_unused;

  // ---------------- ICB decode ----------------
  assign bus.icb_cmd_ready = ~r_rsp_valid | bus.icb_rsp_ready;
  assign bus.icb_rsp_valid = r_rsp_valid;
  assign bus.icb_rsp_err   = r_rsp_err;
  assign bus.icb_rsp_rdata = r_rsp_rdata;

  assign w_accept     = bus.icb_cmd_valid & bus.icb_cmd_ready;
  assign w_wr         = w_accept & ~bus.icb_cmd_read;
  assign w_widx       = bus.icb_cmd_addr[11:2];
  assign w_ctrl_wr    = w_wr && (w_widx == 10'h000);
  assign w_start      = w_ctrl_wr & bus.icb_cmd_wdata[0];
  assign w_abort      = w_ctrl_wr & bus.icb_cmd_wdata[1];
  assign w_release    = {2{w_ctrl_wr}} & bus.icb_cmd_wdata[9:8];
  assign w_card_ready = (core_card_stat == CARD_READY_STAT);
  assign w_status     = {r_remaining, 8'h00, core_card_type, w_card_ready, r_full, r_err, r_done, w_busy};
  // Byte mask and undecoded address bits are intentionally ignored (full-word access only).
  assign w_unused     = ^{bus.icb_cmd_wmask, bus.icb_cmd_addr[31:12], bus.icb_cmd_addr[1:0]};

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_rdata  = '0;
    w_rd_err = 1'b0;
    if (w_widx[9:8] == 2'b01) begin
      w_rdata = r_buf[w_widx[7:0]];  // 0x400..0x7FC: bank0 then bank1
    end else begin
      case (w_widx)
        10'h000: w_rdata = {29'd0, r_irq_en, 2'b00};
        10'h001: w_rdata = r_sector;
        10'h002: w_rdata = {16'd0, r_count};
        10'h003: w_rdata = w_status;
        default: w_rd_err = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_rd_err;
      r_rsp_rdata <= bus.icb_cmd_read ? w_rdata : 32'd0;
    end else if (bus.icb_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // rdone in the last timer cycle still completes the sector.
  assign w_timeout     = (r_state == S_XFER) && !core_rdone && (r_timer == TIMEOUT - 24'd1);
  assign w_fill_done   = (r_state == S_XFER) && core_rdone && !w_abort;
  assign w_enter_abort = (w_next == S_ABORT) && (r_state != S_ABORT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start && w_card_ready && (r_count != 16'd0)) w_next = S_WAIT_BUF;
      S_WAIT_BUF: if (!r_full[r_fill_bank]) w_next = S_ISSUE;
      S_ISSUE:    w_next = S_XFER;
      S_XFER: begin
        if (core_rdone)     w_next = (r_remaining == 16'd1) ? S_IDLE : S_WAIT_BUF;
        else if (w_timeout) w_next = S_ABORT;
      end
      S_ABORT:    if (!core_rbusy) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_abort && (r_state != S_IDLE)) w_next = S_ABORT;
  end

  always_comb begin
    core_rstart = (r_state == S_ISSUE);
    w_busy      = (r_state != S_IDLE);
  end

  assign core_rsector = r_cur_sector;
  assign irq          = r_irq_en & (r_done | r_err | r_full[0] | r_full[1]);

  // ---------------- Control / status datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en     <= 1'b0;
      r_sector     <= '0;
      r_count      <= '0;
      r_cur_sector <= '0;
      r_remaining  <= '0;
      r_fill_bank  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_timer      <= '0;
      r_full       <= '0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= bus.icb_cmd_wdata[2];
      if (w_wr && (w_widx == 10'h001)) r_sector <= bus.icb_cmd_wdata;
      if (w_wr && (w_widx == 10'h002)) r_count  <= bus.icb_cmd_wdata[15:0];

      if ((r_state == S_IDLE) && w_start) begin
        if (!w_card_ready) begin
          r_err <= 1'b1;
        end else if (r_count == 16'd0) begin
          r_done <= 1'b1;
        end else begin
          r_cur_sector <= r_sector;
          r_remaining  <= r_count;
          r_fill_bank  <= 1'b0;
          r_done       <= 1'b0;
          r_err        <= 1'b0;
        end
      end

      if (r_state == S_ISSUE)     r_timer <= '0;
      else if (r_state == S_XFER) r_timer <= r_timer + 24'd1;

      if (w_timeout) r_err <= 1'b1;

      if (w_fill_done) begin
        r_fill_bank  <= ~r_fill_bank;
        r_cur_sector <= r_cur_sector + 32'd1;
        r_remaining  <= r_remaining - 16'd1;
        if (r_remaining == 16'd1) r_done <= 1'b1;
      end

      // Fill-complete beats a same-cycle release of the same bank.
      for (int b = 0; b < 2; b++) begin
        if (w_enter_abort)                             r_full[b] <= 1'b0;
        else if (w_fill_done && (r_fill_bank == 1'(b))) r_full[b] <= 1'b1;
        else if (w_release[b])                         r_full[b] <= 1'b0;
      end
    end
  end

  // NOTE: the bank storage has no reset; contents are only meaningful once the full flag is set.
  always_ff @(posedge clk) begin
    if ((r_state == S_XFER) && core_outen)
      r_buf[{r_fill_bank, core_outaddr[8:2]}][core_outaddr[1:0]] <= core_outbyte;
  end

endmodule
